link_credit_arbiter: RTL
========================

Name: link_credit_arbiter

Overview:
- Sits in front of the off-chip serializer's byte input (data_in/valid_in/ready side).
- Shares the serializer between NUM_REQ byte requesters using round-robin arbitration.
- Tracks downstream nibble-slot credits, which are returned by the read-side token, so that no byte is issued without two free buffer slots.
- Exposes credit level, the last grant, stall count and an overflow error for debug.

Parameters:
NUM_REQ, 2, number of byte requesters (2..8)
CREDITS, 8, downstream 4-bit slots available after reset (8-entry nibble memory)
SLOTS_PER_BYTE, 2, credits consumed per granted byte
CRED_W, 4, credit counter width; must hold CREDITS
STALL_W, 16, stall counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = new grants allowed
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept; transfer on req_valid[i] & req_ready[i]
link_data  out  8  byte to serializer
link_valid  out  1  link_data valid
link_ready  in  1  serializer accepts (its IDLE/STOR states)
credit_ret  in  1  one-cycle pulse = one slot freed downstream
credits  out  CRED_W  current credit count
grant_id  out  3  index of last granted requester
credit_stall  out  1  high while in WAIT_CREDIT
stall_cycles  out  STALL_W  saturating count of WAIT_CREDIT cycles
credit_err  out  1  sticky; credit return seen while credits == CREDITS

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, link_valid = 0, link_data = 0, req_ready = 0.
  - credits = CREDITS, grant_id = 0, last-grant pointer = NUM_REQ-1, so requester 0 wins first.
  - credit_stall = 0, stall_cycles = 0, credit_err = 0.
- req_ready is combinational from registered state. It is forced to 0 while rst is high.
- States: IDLE, SEND, WAIT_CREDIT.
- IDLE:
  - When enable = 1, any req_valid = 1 and credits >= SLOTS_PER_BYTE:
    - Pick the winner g by round-robin: first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
    - req_ready[g] = 1 in the same cycle.
    - Next edge: link_data <= req_data[g], link_valid <= 1, grant_id <= g, last_grant <= g, credits reserved (-SLOTS_PER_BYTE), go to SEND.
  - When enable = 1, any req_valid = 1 and credits < SLOTS_PER_BYTE: go to WAIT_CREDIT.
  - When enable = 0: stay in IDLE, req_ready = 0.
- SEND:
  - link_valid = 1; link_data holds stable until link_ready = 1.
  - On link_valid & link_ready: next edge link_valid <= 0, go to IDLE.
  - Minimum spacing between grants is 2 cycles.
  - Deasserting enable does not abort SEND.
- WAIT_CREDIT:
  - credit_stall = 1; stall_cycles increments each cycle and saturates at all-ones.
  - Go to IDLE when credits >= SLOTS_PER_BYTE, or when no req_valid is set, or when enable = 0.
- Credit arithmetic, every cycle:
  - next = credits - (grant ? SLOTS_PER_BYTE : 0) + (credit_ret ? 1 : 0).
  - A simultaneous grant and return gives net -1.
  - If credit_ret arrives with credits == CREDITS and no grant that cycle: credits stay at CREDITS and credit_err <= 1 (sticky until reset).
  - Credits never underflow, because a grant requires credits >= SLOTS_PER_BYTE.
- A req_valid dropped before grant is ignored, with no stale capture. Requesters need not hold data after the handshake.
- Reset mid-SEND drops the byte; credits return to CREDITS.

Test Plan:
- Reset, then req_valid = 2'b01, req_data[7:0] = 8'h5A, link_ready = 1 -> req_ready = 2'b01 in the same cycle; next cycle link_valid = 1 with 8'h5A; credits 8 -> 6; grant_id = 0.
- Both requesters valid continuously (8'h11 and 8'h22), link_ready = 1, no credit_ret -> grants alternate 0,1,0,1; then credits = 0, credit_stall = 1 and stall_cycles counts.
- From credits = 0 in WAIT_CREDIT: two credit_ret pulses -> credits = 2; IDLE next; grant goes to requester 0 (next in rotation after 1).
- link_ready held 0 for 5 cycles during SEND -> link_data/link_valid stable; req_ready = 0; no second grant.
- Grant and credit_ret in the same cycle at credits = 4 -> credits = 3. credit_ret at credits = 8 -> credits stays 8, credit_err = 1, and it persists.
- Assert rst asynchronously mid-SEND -> link_valid = 0 immediately; credits = 8; after release requester 0 has priority.

Source files
------------

// File: rtl/link_credit_arbiter.sv
// link_credit_arbiter
//   Shares the off-chip serializer byte input between NUM_REQ requesters
//   with round-robin arbitration. No byte is issued unless the downstream
//   nibble buffer has SLOTS_PER_BYTE free slots. Slots are freed one at a
//   time by credit_ret pulses from the read side.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   enable        1 = new grants allowed
//   req_valid     per-requester byte valid
//   req_data      per-requester byte, requester i at [8i+7:8i]
//   req_ready     one-hot accept, combinational from registered state
//   link_data     byte to the serializer
//   link_valid    link_data valid
//   link_ready    serializer can take a byte
//   credit_ret    one-cycle pulse, one downstream slot freed
//   credits       current free-slot count
//   grant_id      index of the last granted requester
//   credit_stall  high while waiting for credits
//   stall_cycles  saturating count of cycles spent waiting for credits
//   credit_err    sticky, credit returned while already full
module link_credit_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CREDITS        = 8,
  parameter int SLOTS_PER_BYTE = 2,
  parameter int CRED_W         = 4,
  parameter int STALL_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           link_data,
  output logic                 link_valid,
  input  logic                 link_ready,
  input  logic                 credit_ret,
  output logic [CRED_W-1:0]    credits,
  output logic [2:0]           grant_id,
  output logic                 credit_stall,
  output logic [STALL_W-1:0]   stall_cycles,
  output logic                 credit_err
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_CREDIT = 2'd2
  } state_t;

  localparam logic [CRED_W-1:0] CRED_MAX   = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] CRED_SLOTS = CRED_W'(SLOTS_PER_BYTE);
  localparam logic [2:0]        LAST_RST   = 3'(NUM_REQ - 1);

  state_t     state;
  logic [2:0] last_grant;

  logic       any_req;
  logic       have_credit;
  logic       grant;
  logic       full_ret;
  logic [2:0] winner;
  logic [7:0] sel_data;

  // Credit update: reserve on grant, add one per return. A return with the
  // buffer already full (and no grant to absorb it) is dropped.
  function automatic logic [CRED_W-1:0] credit_next(
    input logic [CRED_W-1:0] cur,
    input logic              take,
    input logic              give
  );
    logic [CRED_W:0] sum;
    sum = {1'b0, cur};
    if (take) sum = sum - {1'b0, CRED_SLOTS};
    if (give) sum = sum + {{CRED_W{1'b0}}, 1'b1};
    if (give && !take && (cur == CRED_MAX)) sum = {1'b0, cur};
    return sum[CRED_W-1:0];
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  assign any_req     = |req_valid;
  assign have_credit = (credits >= CRED_SLOTS);
  assign grant       = (state == IDLE) && enable && any_req && have_credit;
  assign full_ret    = credit_ret && !grant && (credits == CRED_MAX);

  // Round-robin pick: first valid above the last grant, else first valid
  // from index 0 (wrap-around).
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last_grant))) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  // Accept is held low during reset so nothing is consumed while the
  // arbiter state is being cleared.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = grant && (winner == 3'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      link_valid   <= 1'b0;
      link_data    <= '0;
      credits      <= CRED_MAX;
      grant_id     <= '0;
      last_grant   <= LAST_RST;
      credit_stall <= 1'b0;
      stall_cycles <= '0;
      credit_err   <= 1'b0;
    end else begin
      credits <= credit_next(credits, grant, credit_ret);
      if (full_ret) credit_err <= 1'b1;

      case (state)
        IDLE: begin
          if (grant) begin
            link_data  <= sel_data;
            link_valid <= 1'b1;
            grant_id   <= winner;
            last_grant <= winner;
            state      <= SEND;
          end else if (enable && any_req) begin
            credit_stall <= 1'b1;
            state        <= WAIT_CREDIT;
          end
        end
        SEND: begin
          if (link_ready) begin
            link_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        WAIT_CREDIT: begin
          stall_cycles <= sat_inc(stall_cycles);
          if (have_credit || !any_req || !enable) begin
            credit_stall <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          credit_stall <= 1'b0;
          link_valid   <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
